uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/uart_tx_framed.sv | 155 +++++++++++++++
 tb/tb_uart_tx_framed.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM states, parity
// encodings and the symbol-time helper.
package uart_pkg;

    // ST_BREAK is only reachable when UART_TX_BREAK_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int symbol_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-symbol down counter: reloads on load or at terminal count, and ticks
// on the last cycle of each symbol so symbols abut without gaps.
module uart_baud_counter #(
    parameter int SYMBOL_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYMBOL_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load || tick)
            count <= LAST;
        else
            count <= count - CW'(1);
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter (start, LSB-first data, optional parity, 1-2 stops).
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 serial_out,
    output logic                 busy
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                 send_break
`endif
);

    localparam int S  = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    state_t               state;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [BW-1:0]        bit_idx;
    logic                 accept;
    logic                 load;
    logic                 tick;

    assign accept = (state == ST_IDLE) && data_in_ready && data_in_valid;

    always_comb begin
        load = accept;
`ifdef UART_TX_BREAK_EN
        if (state == ST_BREAK && !send_break)
            load = 1'b1;
`endif
    end

    uart_baud_counter #(
        .SYMBOL_CYCLES(S)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .tick (tick)
    );

    // NOTE: shift_q carries payload only and is always loaded before use, so
    // it is deliberately left out of reset; all state uses non-blocking <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            serial_out    <= 1'b1;
            busy          <= 1'b0;
            data_in_ready <= 1'b0;
            bit_idx       <= '0;
            parity_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= ST_START;
                        serial_out    <= 1'b0;
                        busy          <= 1'b1;
                        data_in_ready <= 1'b0;
                        shift_q       <= data_in;
                        parity_q      <= (PARITY == PARITY_ODD) ? ~^data_in : ^data_in;
                    end
`ifdef UART_TX_BREAK_EN
                    else if (send_break) begin
                        state         <= ST_BREAK;
                        serial_out    <= 1'b0;
                        busy          <= 1'b1;
                        data_in_ready <= 1'b0;
                    end
`endif
                    else begin
                        serial_out    <= 1'b1;
                        busy          <= 1'b0;
                        data_in_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state      <= ST_DATA;
                        serial_out <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_idx    <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state      <= ST_PARITY;
                                serial_out <= parity_q;
                            end else begin
                                state      <= ST_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            bit_idx    <= bit_idx + BW'(1);
                            serial_out <= shift_q[0];
                            shift_q    <= shift_q >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state      <= ST_STOP;
                        serial_out <= 1'b1;
                        bit_idx    <= '0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == BW'(STOP_BITS - 1)) begin
                            state         <= ST_IDLE;
                            busy          <= 1'b0;
                            data_in_ready <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                // Releasing a break reuses the last stop symbol as the
                // mandatory S cycles of idle-high line before ready returns.
                ST_BREAK: begin
                    if (!send_break) begin
                        state      <= ST_STOP;
                        serial_out <= 1'b1;
                        bit_idx    <= BW'(STOP_BITS - 1);
                    end
                end
`endif
                default: begin
                    state         <= ST_IDLE;
                    serial_out    <= 1'b1;
                    busy          <= 1'b0;
                    data_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: 8N1, 7E2 and 8O1 instances at S=10,
// checked against a symbol-level frame model (break test with UART_TX_BREAK_EN).
module tb_uart_tx_framed;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int S      = CLK_HZ / BAUD;
    localparam int LIMIT  = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] din [3];
    logic [2:0] valid;
    wire  [2:0] ready;
    wire  [2:0] ser;
    wire  [2:0] busy;
`ifdef UART_TX_BREAK_EN
    logic [2:0] brk;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_framed #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .data_in(din[0][7:0]), .data_in_valid(valid[0]),
        .data_in_ready(ready[0]), .serial_out(ser[0]), .busy(busy[0])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[0])
`endif
    );

    uart_tx_framed #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
                     .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .reset(reset), .data_in(din[1][6:0]), .data_in_valid(valid[1]),
        .data_in_ready(ready[1]), .serial_out(ser[1]), .busy(busy[1])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[1])
`endif
    );

    uart_tx_framed #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .data_in(din[2][7:0]), .data_in_valid(valid[2]),
        .data_in_ready(ready[2]), .serial_out(ser[2]), .busy(busy[2])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[2])
`endif
    );

    // Frame model: configuration of each instance and the line level of
    // symbol number sym (0 = start) for a payload d.
    function automatic int nbits(input int idx);
        return (idx == 1) ? 7 : 8;
    endfunction

    function automatic int npar(input int idx);
        return (idx == 0) ? 0 : ((idx == 1) ? 2 : 1);
    endfunction

    function automatic int nstop(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int idx);
        return 1 + nbits(idx) + ((npar(idx) != 0) ? 1 : 0) + nstop(idx);
    endfunction

    function automatic logic exp_bit(input int idx, input logic [8:0] d, input int sym);
        int ones = 0;
        if (sym == 0)
            return 1'b0;
        if (sym <= nbits(idx))
            return d[sym-1];
        if (npar(idx) != 0 && sym == nbits(idx) + 1) begin
            for (int b = 0; b < nbits(idx); b++)
                ones += int'(d[b]);
            // Even parity makes the total count of ones even, odd makes it odd.
            return (npar(idx) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int idx, input logic [8:0] d, output int latency);
        din[idx]   = d;
        valid[idx] = 1'b1;
        latency    = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (ser[idx] !== 1'b0 && latency < LIMIT);
        check($sformatf("start_seen u%0d", idx), ser[idx], 0);
    endtask

    task automatic run_frame(input int idx, input logic [8:0] d, input bit keep_valid,
                             output int onset);
        int lat;
        int n;
        n = flen(idx) * S;
        start_frame(idx, d, lat);
        onset = cyc;
        check($sformatf("start_latency u%0d", idx), lat, 1);
        if (!keep_valid)
            valid[idx] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0)
                @(negedge clk);
            check($sformatf("serial u%0d sym%0d", idx, i / S), ser[idx], exp_bit(idx, d, i / S));
            check($sformatf("busy_in_frame u%0d", idx), busy[idx], 1);
            check($sformatf("ready_in_frame u%0d", idx), ready[idx], 0);
            din[idx] = 9'($urandom);
        end
        @(negedge clk);
        check($sformatf("ready_after_frame u%0d", idx), ready[idx], 1);
        check($sformatf("busy_after_frame u%0d", idx), busy[idx], 0);
        check($sformatf("idle_line u%0d", idx), ser[idx], 1);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int o1, o2, lat, idx;
        logic [8:0] d;

        reset = 1'b1;
        valid = '0;
        for (int i = 0; i < 3; i++) din[i] = '0;
`ifdef UART_TX_BREAK_EN
        brk = '0;
`endif
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready u%0d", i), ready[i], 0);
            check($sformatf("reset_line u%0d", i), ser[i], 1);
            check($sformatf("reset_busy u%0d", i), busy[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("ready_after_reset u%0d", i), ready[i], 1);

        // Directed frames: 8N1 0xA5, 7E2 0x41, 8O1 0x00.
        run_frame(0, 9'h0A5, 1'b0, o1);
        run_frame(1, 9'h041, 1'b0, o1);
        run_frame(2, 9'h000, 1'b0, o1);

        // Back-to-back with valid held high.
        run_frame(0, 9'h012, 1'b1, o1);
        run_frame(0, 9'h034, 1'b0, o2);
        check("b2b_spacing", o2 - o1, flen(0) * S + 1);

        // Randomized frames on randomly chosen instances.
        for (int k = 0; k < 6; k++) begin
            idx = $urandom_range(0, 2);
            d   = 9'($urandom);
            run_frame(idx, d, 1'b0, o1);
        end

        // Reset at cycle 35 of a frame aborts it for good.
        start_frame(0, 9'h0FF, lat);
        valid[0] = 1'b0;
        repeat (34) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_line", ser[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_ready", ready[0], 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", ready[0], 1);
        for (int i = 0; i < 20; i++) begin
            check("abort_no_resume", ser[0], 1);
            @(negedge clk);
        end

`ifdef UART_TX_BREAK_EN
        brk[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("break_line", ser[0], 0);
            check("break_ready", ready[0], 0);
            check("break_busy", busy[0], 1);
        end
        brk[0] = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            check("break_recover_line", ser[0], 1);
            check("break_recover_ready", ready[0], 0);
        end
        @(negedge clk);
        check("break_ready_rise", ready[0], 1);
        check("break_busy_end", busy[0], 0);
        run_frame(0, 9'h05A, 1'b0, o1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
